// File: rtl/led_display_controller.sv
// Avalon-MM LED / seven-segment controller: readback registers, per-LED blink,
// hex-to-segment decode with per-digit enable, and global PWM brightness.
module led_display_controller #(
  parameter int unsigned NUM_LEDS       = 10,
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned BLINK_DIV      = 25000000,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              address,
  input  logic [3:0]              byteenable,
  input  logic [31:0]             writedata,
  input  logic                    write,
  input  logic                    read,
  output logic [31:0]             readdata,
  output logic [NUM_LEDS-1:0]     leds,
  output logic [7*NUM_DIGITS-1:0] sevenseg
);

  localparam int unsigned HEX_W = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W = 7 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : '0;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  // Active-high glyphs, bit order g..a
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  logic [NUM_LEDS-1:0]   led_data;
  logic [NUM_LEDS-1:0]   blink_msk;
  logic [HEX_W-1:0]      hex_val;
  logic [NUM_DIGITS-1:0] dig_en;
  logic [7:0]            duty;
  logic                  blink_en;
  logic [CNT_W-1:0]      blink_cnt;
  logic                  phase;
  logic [7:0]            pwm_cnt;
  logic                  pwm_on;
  logic [31:0]           reg_rd;
  logic [31:0]           ctrl_rd;
  logic [SEG_W-1:0]      seg_lit;
  logic [SEG_W-1:0]      seg_c;

  assign ctrl_rd = {15'd0, blink_en, duty, 8'(dig_en)};

  always_comb begin
    reg_rd = '0;
    case (address)
      2'd0:    reg_rd = 32'(led_data);
      2'd1:    reg_rd = 32'(blink_msk);
      2'd2:    reg_rd = 32'(hex_val);
      default: reg_rd = ctrl_rd;
    endcase
  end

  // Register file with per-lane writes; reads capture the pre-write value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_data  <= '0;
      blink_msk <= '0;
      hex_val   <= '0;
      dig_en    <= '0;
      duty      <= 8'hFF;
      blink_en  <= 1'b0;
      readdata  <= '0;
    end else begin
      if (read) readdata <= reg_rd;
      if (write) begin
        case (address)
          2'd0: led_data  <= NUM_LEDS'(lane_merge(32'(led_data), writedata, byteenable));
          2'd1: blink_msk <= NUM_LEDS'(lane_merge(32'(blink_msk), writedata, byteenable));
          2'd2: hex_val   <= HEX_W'(lane_merge(32'(hex_val), writedata, byteenable));
          default: begin
            if (byteenable[0]) dig_en   <= writedata[NUM_DIGITS-1:0];
            if (byteenable[1]) duty     <= writedata[15:8];
            if (byteenable[2]) blink_en <= writedata[16];
          end
        endcase
      end
    end
  end

  // Blink prescaler: held at zero while disabled, so enabling restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on = (duty == 8'hFF) || (pwm_cnt < duty);

  always_comb begin
    seg_lit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_lit[7*i +: 7] = (dig_en[i] && pwm_on) ? hex_decode(hex_val[4*i +: 4]) : 7'h00;
    end
    seg_c = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds     <= '0;
      sevenseg <= SEG_OFF;
    end else begin
      leds     <= led_data & ~(blink_msk & {NUM_LEDS{blink_en & phase}}) & {NUM_LEDS{pwm_on}};
      sevenseg <= seg_c;
    end
  end

endmodule

// File: tb/tb_led_display_controller.sv
// Directed self-checking bench for led_display_controller (BLINK_DIV=4).
module tb_led_display_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic [31:0] readdata;
  logic [9:0]  leds;
  logic [41:0] sevenseg;

  int total  = 0;
  int passed = 0;

  localparam logic [41:0] SEG_ALL_OFF = 42'h3FF_FFFF_FFFF;
  // digits 5..0 = A,5,1,2,3,4 active-low
  localparam logic [41:0] SEG_T3 = {7'b0001000, 7'b0010010, 7'b1111001,
                                    7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [41:0] SEG_EN05 = {7'b1111111, 7'b1111111, 7'b1111111,
                                      7'b0100100, 7'b1111111, 7'b0011001};

  led_display_controller #(
    .NUM_LEDS(10), .NUM_DIGITS(6), .BLINK_DIV(4), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .writedata(writedata), .write(write), .read(read), .readdata(readdata),
    .leds(leds), .sevenseg(sevenseg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  initial begin
    logic [31:0] rv;
    int lit, dark, slit, sdark;

    reset = 1'b1; address = '0; byteenable = '0; writedata = '0; write = 1'b0; read = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_leds", 64'(leds), 64'h0);
    chk("rst_seg", 64'(sevenseg), 64'(SEG_ALL_OFF));
    chk("rst_rdata", 64'(readdata), 64'h0);
    reset = 1'b0;
    rd(2'd3, rv);
    chk("rst_ctrl", 64'(rv), 64'h0000_FF00);

    // byte-lane masked write and 2-edge latency
    wr(2'd0, 32'h0000_03FF, 4'b0001);
    chk("led_lat1", 64'(leds), 64'h0);
    @(negedge clk);
    chk("led_lat2", 64'(leds), 64'h0FF);
    rd(2'd0, rv);
    chk("led_rb", 64'(rv), 64'h0FF);
    wr(2'd0, 32'hFFFF_FFFF, 4'b1111);
    rd(2'd0, rv);
    chk("led_unimpl", 64'(rv), 64'h3FF);

    // hex decode
    wr(2'd2, 32'h00A5_1234, 4'b1111);
    wr(2'd3, 32'h0000_FF3F, 4'b1111);
    @(negedge clk);
    chk("seg_t3", 64'(sevenseg), 64'(SEG_T3));
    rd(2'd2, rv);
    chk("hex_rb", 64'(rv), 64'h00A5_1234);
    wr(2'd3, 32'h0000_0005, 4'b0001);
    @(negedge clk);
    chk("seg_en05", 64'(sevenseg), 64'(SEG_EN05));
    wr(2'd3, 32'h0000_FFFF, 4'b0011);
    rd(2'd3, rv);
    chk("ctrl_en_mask", 64'(rv), 64'h0000_FF3F);

    // blink
    wr(2'd1, 32'h0000_000F, 4'b1111);
    wr(2'd3, 32'h0001_FF3F, 4'b1111);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("blink_%0d", k), 64'(leds), (((k / 4) % 2) == 0) ? 64'h3FF : 64'h3F0);
    end
    wr(2'd3, 32'h0000_FF3F, 4'b1111);
    chk("blink_off_last", 64'(leds), 64'h3F0);
    @(negedge clk);
    chk("blink_off", 64'(leds), 64'h3FF);

    // PWM duty 0x40
    wr(2'd3, 32'h0000_4000, 4'b0010);
    @(negedge clk);
    lit = 0; dark = 0; slit = 0; sdark = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (leds == 10'h3FF) lit++;
      else if (leds == 10'h000) dark++;
      if (sevenseg == SEG_T3) slit++;
      else if (sevenseg == SEG_ALL_OFF) sdark++;
    end
    chk("pwm_led_lit", 64'(lit), 64'd64);
    chk("pwm_led_dark", 64'(dark), 64'd192);
    chk("pwm_seg_lit", 64'(slit), 64'd64);
    chk("pwm_seg_dark", 64'(sdark), 64'd192);

    // duty 0 -> dark
    wr(2'd3, 32'h0000_0000, 4'b0010);
    @(negedge clk);
    lit = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (leds != 10'h000 || sevenseg != SEG_ALL_OFF) lit++;
    end
    chk("pwm_zero", 64'(lit), 64'd0);

    // same-cycle read + write
    wr(2'd3, 32'h0000_FF00, 4'b0010);
    wr(2'd1, 32'h0000_0005, 4'b1111);
    @(negedge clk);
    address = 2'd1; writedata = 32'h0000_02AA; byteenable = 4'b1111; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk("rw_old", 64'(readdata), 64'h005);
    @(negedge clk);
    chk("rd_hold", 64'(readdata), 64'h005);
    rd(2'd1, rv);
    chk("rw_new", 64'(rv), 64'h2AA);

    // reset mid-blink / mid-PWM
    wr(2'd3, 32'h0001_803F, 4'b1111);
    repeat (6) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_leds", 64'(leds), 64'h0);
    chk("mid_rst_seg", 64'(sevenseg), 64'(SEG_ALL_OFF));
    chk("mid_rst_rdata", 64'(readdata), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd3, rv);
    chk("mid_rst_ctrl", 64'(rv), 64'h0000_FF00);
    rd(2'd0, rv);
    chk("mid_rst_led", 64'(rv), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
